// File: rtl/rr_bus_arbiter_4x1_pkg.sv
// Shared constants and types for the four-way round-robin bus arbiter.
package rr_bus_arbiter_4x1_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // One-hot grant vector for a requester index.
  function automatic logic [N_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4x1_32.sv
// 32-bit 4:1 multiplexer.
//   i_d0..i_d3 : data inputs
//   i_sel      : select
//   o_y        : selected data
module mux4x1_32
  import rr_bus_arbiter_4x1_pkg::*;
(
  input  logic [BUS_W-1:0] i_d0,
  input  logic [BUS_W-1:0] i_d1,
  input  logic [BUS_W-1:0] i_d2,
  input  logic [BUS_W-1:0] i_d3,
  input  logic [IDX_W-1:0] i_sel,
  output logic [BUS_W-1:0] o_y
);

  always_comb begin
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Circular priority pick: first set request scanning from i_ptr upward, mod 4.
//   i_req  : request vector
//   i_ptr  : highest-priority index this cycle
//   o_idx  : winning index (i_ptr when nothing requested)
//   o_any  : at least one request set
module rr_pick4
  import rr_bus_arbiter_4x1_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    w_idx   = '0;
    w_found = 1'b0;
    o_idx   = i_ptr;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      w_idx = i_ptr + IDX_W'(off);
      if (!w_found && i_req[w_idx]) begin
        o_idx   = w_idx;
        w_found = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/rr_bus_arbiter_4x1.sv
// Round-robin arbiter sharing one 32-bit bus among four requesters with a
// bounded burst length.
//   CLK, RST        : clock, asynchronous active-high reset
//   REQ[3:0]        : level-sensitive requests
//   D0..D3          : requester data
//   GNT[3:0]        : registered one-hot grant (0000 when idle)
//   SEL[1:0]        : registered owner index, held while idle
//   VALID           : registered, equals |GNT
//   Y               : D[SEL] gated by VALID
module rr_bus_arbiter_4x1
  import rr_bus_arbiter_4x1_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  input  logic [BUS_W-1:0] D0,
  input  logic [BUS_W-1:0] D1,
  input  logic [BUS_W-1:0] D2,
  input  logic [BUS_W-1:0] D3,
  output logic [N_REQ-1:0] GNT,
  output logic [IDX_W-1:0] SEL,
  output logic             VALID,
  output logic [BUS_W-1:0] Y
);

  state_e           r_state, w_nxt_state;
  logic [N_REQ-1:0] r_gnt, w_nxt_gnt;
  logic [IDX_W-1:0] r_sel, w_nxt_sel;
  logic [IDX_W-1:0] r_ptr, w_nxt_ptr;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic             r_valid;
  logic             w_grant_new;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_others;
  logic [BUS_W-1:0] w_mux_y;

  rr_pick4 u_pick (
    .i_req (REQ),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Someone other than the current owner is asking.
  assign w_others = |(REQ & ~r_gnt);

  // Next-state and grant decision.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_sel   = r_sel;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    w_grant_new = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) w_grant_new = 1'b1;
      end
      ST_OWN: begin
        if (!REQ[r_sel]) begin
          // Owner released: hand off on this edge or fall idle.
          if (w_pick_any) begin
            w_grant_new = 1'b1;
          end else begin
            w_nxt_gnt   = '0;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_IDLE;
          end
        end else if (r_cnt == CNT_W'(MAX_BURST)) begin
          // Burst exhausted: rotate only if contended, else hold saturated.
          if (w_others) w_grant_new = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    if (w_grant_new) begin
      w_nxt_state = ST_OWN;
      w_nxt_gnt   = onehot4(w_pick_idx);
      w_nxt_sel   = w_pick_idx;
      w_nxt_ptr   = w_pick_idx + IDX_W'(1);
      w_nxt_cnt   = CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_sel   <= w_nxt_sel;
      r_ptr   <= w_nxt_ptr;
      r_cnt   <= w_nxt_cnt;
      r_valid <= |w_nxt_gnt;
    end
  end

  mux4x1_32 u_mux (
    .i_d0  (D0),
    .i_d1  (D1),
    .i_d2  (D2),
    .i_d3  (D3),
    .i_sel (r_sel),
    .o_y   (w_mux_y)
  );

  assign GNT   = r_gnt;
  assign SEL   = r_sel;
  assign VALID = r_valid;
  assign Y     = w_mux_y & {BUS_W{r_valid}};

endmodule

// File: tb/tb_rr_bus_arbiter_4x1.sv
// Directed testbench for rr_bus_arbiter_4x1 (MAX_BURST=4).
module tb_rr_bus_arbiter_4x1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  REQ = 4'b1111;
  logic [31:0] dv [4];
  logic [31:0] D0, D1, D2, D3;
  logic [3:0]  GNT;
  logic [1:0]  SEL;
  logic        VALID;
  logic [31:0] Y;

  int n_vec = 0;
  int n_err = 0;

  assign D0 = dv[0];
  assign D1 = dv[1];
  assign D2 = dv[2];
  assign D3 = dv[3];

  rr_bus_arbiter_4x1 #(.MAX_BURST(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .GNT(GNT), .SEL(SEL), .VALID(VALID), .Y(Y)
  );

  always #5 CLK = ~CLK;

  // Advance one edge and settle; inputs driven here apply at the next edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Short reset pulse between edges.
  task automatic do_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({GNT, VALID, Y} !== {4'b0000, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_async: got gnt=%b valid=%b y=%h want 0000 0 0", GNT, VALID, Y);
    end
    step();
    RST = 1'b0;
    REQ = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({GNT, SEL, VALID, Y} !== {4'b0000, 2'd0, 1'b0, 32'h0}) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got gnt=%b sel=%0d valid=%b y=%h want 0000 0 0 0",
                 i, GNT, SEL, VALID, Y);
      end
    end
  endtask

  task automatic test_single();
    dv[2] = 32'hDEADBEEF;
    REQ = 4'b0100;
    step();
    n_vec++;
    if ({GNT, SEL, VALID, Y} !== {4'b0100, 2'd2, 1'b1, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL single_grant: got gnt=%b sel=%0d valid=%b y=%h want 0100 2 1 deadbeef",
               GNT, SEL, VALID, Y);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({GNT, Y} !== {4'b0100, 32'hDEADBEEF}) begin
        n_err++;
        $display("FAIL single_hold[%0d]: got gnt=%b y=%h want 0100 deadbeef", i, GNT, Y);
      end
    end
    REQ = 4'b0000;
    step();
    n_vec++;
    if ({GNT, SEL, VALID, Y} !== {4'b0000, 2'd2, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL single_release: got gnt=%b sel=%0d valid=%b y=%h want 0000 2 0 0",
               GNT, SEL, VALID, Y);
    end
  endtask

  task automatic test_contention();
    logic [1:0] es;
    REQ = 4'b1111;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step();
      es = 2'((i / 4) % 4);
      n_vec++;
      if ({GNT, SEL, VALID, Y} !== {4'b0001 << es, es, 1'b1, dv[es]}) begin
        n_err++;
        $display("FAIL contention[%0d]: got gnt=%b sel=%0d valid=%b y=%h want sel=%0d y=%h",
                 i, GNT, SEL, VALID, Y, es, dv[es]);
      end
    end
  endtask

  task automatic test_back_to_back();
    REQ = 4'b0010;
    do_reset();
    step();
    REQ = 4'b1010;
    step();
    n_vec++;
    if ({GNT, VALID, Y} !== {4'b0010, 1'b1, dv[1]}) begin
      n_err++;
      $display("FAIL b2b_own1: got gnt=%b valid=%b y=%h want 0010 1 %h", GNT, VALID, Y, dv[1]);
    end
    REQ = 4'b1000;
    step();
    n_vec++;
    if ({GNT, SEL, VALID, Y} !== {4'b1000, 2'd3, 1'b1, dv[3]}) begin
      n_err++;
      $display("FAIL b2b_handoff: got gnt=%b sel=%0d valid=%b y=%h want 1000 3 1 %h",
               GNT, SEL, VALID, Y, dv[3]);
    end
    REQ = 4'b0000;
    step();
    n_vec++;
    if ({GNT, VALID, Y} !== {4'b0000, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL b2b_idle: got gnt=%b valid=%b y=%h want 0000 0 0", GNT, VALID, Y);
    end
  endtask

  task automatic test_fairness();
    REQ = 4'b0100;
    do_reset();
    step();
    REQ = 4'b0000;
    step();
    REQ = 4'b1001;
    step();
    n_vec++;
    if ({GNT, SEL} !== {4'b1000, 2'd3}) begin
      n_err++;
      $display("FAIL fair_first: got gnt=%b sel=%0d want 1000 3", GNT, SEL);
    end
    for (int i = 0; i < 3; i++) step();
    n_vec++;
    if (GNT !== 4'b1000) begin
      n_err++;
      $display("FAIL fair_burst_end: got gnt=%b want 1000", GNT);
    end
    step();
    n_vec++;
    if ({GNT, SEL, Y} !== {4'b0001, 2'd0, dv[0]}) begin
      n_err++;
      $display("FAIL fair_rotate: got gnt=%b sel=%0d y=%h want 0001 0 %h", GNT, SEL, Y, dv[0]);
    end
  endtask

  task automatic test_saturate_preempt();
    REQ = 4'b0100;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    REQ = 4'b0101;
    step();
    n_vec++;
    if ({GNT, SEL} !== {4'b0001, 2'd0}) begin
      n_err++;
      $display("FAIL sat_preempt: got gnt=%b sel=%0d want 0001 0", GNT, SEL);
    end
  endtask

  task automatic test_async_reset();
    REQ = 4'b0010;
    do_reset();
    step();
    step();
    n_vec++;
    if (GNT !== 4'b0010) begin
      n_err++;
      $display("FAIL areset_pre: got gnt=%b want 0010", GNT);
    end
    #2;
    RST = 1'b1;
    #1;
    n_vec++;
    if ({GNT, VALID, Y} !== {4'b0000, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL areset_mid: got gnt=%b valid=%b y=%h want 0000 0 0", GNT, VALID, Y);
    end
    #2;
    RST = 1'b0;
    REQ = 4'b1111;
    step();
    n_vec++;
    if ({GNT, SEL, Y} !== {4'b0001, 2'd0, dv[0]}) begin
      n_err++;
      $display("FAIL areset_first: got gnt=%b sel=%0d y=%h want 0001 0 %h", GNT, SEL, Y, dv[0]);
    end
  endtask

  initial begin
    dv[0] = 32'h1111_0000;
    dv[1] = 32'h2222_0101;
    dv[2] = 32'h3333_0202;
    dv[3] = 32'h4444_0303;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_fairness();
    test_saturate_preempt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
